// File: rtl/gauss_frame_ctrl.sv
// Frame sequencer/configurator around the 7x7 Gaussian filter stage.
// Admits only whole input frames, checks their geometry, latches host config
// at frame boundaries and follows the filter output frame to completion.
// Ports:
//   clk, rst_n                     pixel clock, async active-low reset
//   cfg_enable/cfg_bypass/cfg_wr   host config levels, loaded on cfg_wr pulse
//   err_clr                        clears sticky err_flags
//   pre_vs/pre_de/pre_data         input stream
//   flt_vs/flt_de/flt_data         gated stream into the filter
//   post_vs/post_de/post_data/post_orig  filter output (smoothed + centre pixel)
//   res_vs/res_de/res_data         result stream after bypass mux
//   frame_start/frame_done         single-cycle frame event pulses
//   frame_cnt                      completed frames (wrapping)
//   busy                           frame in RUN or DRAIN
//   err_flags                      [0] h size [1] v size [2] SOF in drain [3] drain timeout
module gauss_frame_ctrl #(
  parameter int unsigned IMG_HDISP     = 1280,
  parameter int unsigned IMG_VDISP     = 720,
  parameter int unsigned DRAIN_TIMEOUT = 8388607
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_enable,
  input  logic        cfg_bypass,
  input  logic        cfg_wr,
  input  logic        err_clr,
  input  logic        pre_vs,
  input  logic        pre_de,
  input  logic [7:0]  pre_data,
  output logic        flt_vs,
  output logic        flt_de,
  output logic [7:0]  flt_data,
  input  logic        post_vs,
  input  logic        post_de,
  input  logic [7:0]  post_data,
  input  logic [7:0]  post_orig,
  output logic        res_vs,
  output logic        res_de,
  output logic [7:0]  res_data,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        busy,
  output logic [3:0]  err_flags
);

  localparam int unsigned HW = 13;
  localparam int unsigned VW = 11;
  localparam int unsigned DW = 23;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, RUN, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            pend_en, pend_byp, act_byp;
  logic            pre_vs_d, post_vs_d, pre_de_d;
  logic [HW-1:0]   hcnt, hcnt_inc;
  logic [VW-1:0]   vcnt, vcnt_inc, vcnt_upd;
  logic [DW-1:0]   drain_cnt, drain_inc;
  logic            vs_rise, vs_fall, post_fall, de_fall;
  logic            accept, sof, done;
  logic [3:0]      err_set;

  // Edge detectors on registered copies of the sync inputs
  assign vs_rise   = pre_vs & ~pre_vs_d;
  assign vs_fall   = ~pre_vs & pre_vs_d;
  assign post_fall = ~post_vs & post_vs_d;
  assign de_fall   = ~pre_de & pre_de_d;

  // Saturating geometry increments
  assign hcnt_inc  = (hcnt == '1) ? hcnt : hcnt + HW'(1);
  assign vcnt_inc  = (vcnt == '1) ? vcnt : vcnt + VW'(1);
  // Line count including a line that ends on the vs-fall cycle itself
  assign vcnt_upd  = de_fall ? vcnt_inc : vcnt;
  assign drain_inc = drain_cnt + DW'(1);

  // Next-state decode and frame events
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sof       = 1'b0;
    done      = 1'b0;
    err_set   = '0;
    case (state)
      IDLE: begin
        if (pend_en) state_nxt = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!pend_en) begin
          state_nxt = IDLE;
        end else if (vs_rise) begin
          accept    = 1'b1;
          sof       = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        accept = 1'b1;
        if (de_fall && (hcnt != HW'(IMG_HDISP))) err_set[0] = 1'b1;
        if (vs_fall) begin
          if (vcnt_upd != VW'(IMG_VDISP)) err_set[1] = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // A rise here is consumed: pre_vs_d stays high so it is never seen again
        if (vs_rise) err_set[2] = 1'b1;
        if (post_fall) begin
          done      = 1'b1;
          state_nxt = pend_en ? WAIT_SOF : IDLE;
        end else if (drain_inc == DW'(DRAIN_TIMEOUT)) begin
          err_set[3] = 1'b1;
          state_nxt  = pend_en ? WAIT_SOF : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, config, counters and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend_en     <= 1'b0;
      pend_byp    <= 1'b0;
      act_byp     <= 1'b0;
      // High so a frame already running at reset release yields no rise
      pre_vs_d    <= 1'b1;
      post_vs_d   <= 1'b1;
      pre_de_d    <= 1'b0;
      hcnt        <= '0;
      vcnt        <= '0;
      drain_cnt   <= '0;
      flt_vs      <= 1'b0;
      flt_de      <= 1'b0;
      flt_data    <= '0;
      res_vs      <= 1'b0;
      res_de      <= 1'b0;
      res_data    <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      busy        <= 1'b0;
      err_flags   <= '0;
    end else begin
      state     <= state_nxt;
      pre_vs_d  <= pre_vs;
      post_vs_d <= post_vs;
      pre_de_d  <= pre_de;

      if (cfg_wr) begin
        pend_en  <= cfg_enable;
        pend_byp <= cfg_bypass;
      end
      // Reads the pending value from before any same-cycle cfg_wr
      if (sof) act_byp <= pend_byp;

      if (sof) begin
        hcnt <= pre_de ? HW'(1) : '0;
        vcnt <= '0;
      end else if (state == RUN) begin
        if (pre_de) begin
          hcnt <= hcnt_inc;
        end else if (de_fall) begin
          hcnt <= '0;
          vcnt <= vcnt_inc;
        end
      end

      drain_cnt <= (state == DRAIN) ? drain_inc : '0;

      flt_vs   <= pre_vs & accept;
      flt_de   <= pre_de & accept;
      flt_data <= accept ? pre_data : '0;

      res_vs   <= post_vs;
      res_de   <= post_de;
      res_data <= post_de ? (act_byp ? post_orig : post_data) : '0;

      frame_start <= sof;
      frame_done  <= done;
      if (done) frame_cnt <= frame_cnt + 16'd1;

      busy      <= (state_nxt == RUN) || (state_nxt == DRAIN);
      // Set beats clear in the same cycle
      err_flags <= (err_clr ? 4'b0000 : err_flags) | err_set;
    end
  end

endmodule
